a25_flush_sequencer: RTL and testbench
======================================

# a25_flush_sequencer

Sequences a full invalidation of the Amber 25 cache tag RAM whenever the co-processor requests a flush or cache enable is switched off. It walks every line index in turn and writes an invalid tag to all ways. While it is working it holds the core stalled. It sits between the co-processor 15 control outputs (flush pulse, cache enable) and the cache tag RAM write port, and yields that port to the cache whenever the cache is using it.

## Interface
- LINES, 256, number of line indices per way; a power of two, ≥2
- LINE_W, 8, index width; log2(LINES)
- WAYS, 4, number of ways; all ways are written in parallel
- CNT_W, 16, width of the completed-flush counter

- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_cache_flush  in  1  one-cycle flush request (co-processor CR1 write)
- i_cache_enable  in  1  cache enable level (co-processor CR2 bit 0)
- i_tag_busy  in  1  cache owns the tag RAM port this cycle; no write may issue
- o_tag_wen  out  WAYS  per-way tag write enable; write data is all-zero, tied off outside this block
- o_tag_addr  out  LINE_W  line index being invalidated
- o_flush_busy  out  1  stall request to the core
- o_flush_done  out  1  one-cycle pulse when a pass completes
- o_flush_count  out  CNT_W  number of completed passes, saturating

One clock. Reset is asynchronous and active-high.

## Operation
- Trigger: `trig = i_cache_flush | (enable_d & ~i_cache_enable)`.
  - enable_d is i_cache_enable registered every cycle; its reset value is 0.
  - A falling edge of enable therefore triggers a flush. A rising edge does not.
- States: IDLE, FLUSH, DONE.
- IDLE:
  - On trig, go to FLUSH with addr=0.
  - Otherwise stay in IDLE.
- FLUSH:
  - `o_tag_wen = {WAYS{~i_tag_busy}}`. This is a combinational path from i_tag_busy.
  - When a write issues (i_tag_busy=0):
    - if addr==LINES-1, go to DONE;
    - otherwise addr+1.
  - When i_tag_busy=1, addr and state hold.
  - trig sets `pending`.
- DONE:
  - o_flush_done=1.
  - o_flush_count increments, saturating at all-ones.
  - If pending or trig, go to FLUSH with addr=0 and clear pending.
  - Otherwise go to IDLE.
- Multiple triggers during one pass collapse into a single extra pass.
- o_flush_busy = (state != IDLE).
- o_tag_wen = 0 outside FLUSH.
- o_tag_addr = addr in all states. It is 0 in IDLE.
- addr is LINE_W bits wide. It never wraps; the terminal compare ends the pass.
- Reset values:
  - state=IDLE, addr=0, pending=0, enable_d=0, count=0.
  - Therefore o_flush_busy=0, o_flush_done=0, o_tag_wen=0, o_tag_addr=0, o_flush_count=0.
- Reset mid-pass aborts immediately. The partial invalidation is not resumed, and no done pulse or count increment follows.

## Timing
- A trigger sampled in cycle n puts the block in FLUSH in n+1. o_flush_busy rises in n+1, not combinationally.
- With i_tag_busy held 0:
  - writes occur in cycles n+1 … n+LINES;
  - DONE is in n+LINES+1;
  - IDLE is in n+LINES+2.
  - o_flush_busy is high for LINES+1 cycles.
- Each cycle with i_tag_busy=1 during FLUSH adds exactly one cycle of latency.
- A trigger in the same cycle as DONE starts the next pass in the following cycle, with no IDLE gap. o_flush_done still pulses in that DONE cycle.
- i_cache_flush and an enable falling edge in the same cycle count as one trigger.
- pending is set by trig in FLUSH only. In DONE, trig is consumed directly.

## Test plan
- Reset with LINES=4:
  - During reset: all outputs 0.
  - Release reset, then pulse i_cache_flush at cycle 2.
  - Cycles 3–6: o_tag_wen=4'hF with addr 0,1,2,3.
  - Cycle 7: o_flush_done=1.
  - Cycle 8: busy=0 and o_flush_count=1.
- Backpressure:
  - Same as above, with i_tag_busy=1 in cycles 4 and 5.
  - Addr holds at 1 through cycles 4–6, with wen=0 in cycles 4 and 5.
  - done moves to cycle 9.
- Coalescing:
  - Three i_cache_flush pulses during one pass.
  - Exactly one extra pass with no IDLE gap between passes; count ends at 2.
- Enable edges:
  - Enable 0→1: no flush.
  - Enable 1→0: a flush starts the next cycle.
  - A flush pulse coincident with the enable falling edge produces a single pass.
- Reset mid-pass:
  - Assert i_reset while addr=2.
  - Outputs return to 0 immediately.
  - After release, no done pulse appears and count stays 0.
- Saturation with CNT_W=2:
  - Run 5 passes.
  - o_flush_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/a25_flush_sequencer_if.sv
// a25_flush_sequencer_if: CP15 flush/enable inputs and tag RAM write port
// master drives the requests, slave is the sequencer
interface a25_flush_sequencer_if #(
  parameter int LINE_W = 8,
  parameter int WAYS   = 4,
  parameter int CNT_W  = 16
);
  logic              i_cache_flush;
  logic              i_cache_enable;
  logic              i_tag_busy;
  logic [WAYS-1:0]   o_tag_wen;
  logic [LINE_W-1:0] o_tag_addr;
  logic              o_flush_busy;
  logic              o_flush_done;
  logic [CNT_W-1:0]  o_flush_count;

  modport master (
    output i_cache_flush,
    output i_cache_enable,
    output i_tag_busy,
    input  o_tag_wen,
    input  o_tag_addr,
    input  o_flush_busy,
    input  o_flush_done,
    input  o_flush_count
  );

  modport slave (
    input  i_cache_flush,
    input  i_cache_enable,
    input  i_tag_busy,
    output o_tag_wen,
    output o_tag_addr,
    output o_flush_busy,
    output o_flush_done,
    output o_flush_count
  );
endinterface

// File: rtl/a25_flush_sequencer.sv
// a25_flush_sequencer: walks every tag line writing invalid to all ways,
// stalling the core, on CP15 flush or cache-enable falling edge
module a25_flush_sequencer #(
  parameter int LINES  = 256,
  parameter int LINE_W = 8,
  parameter int WAYS   = 4,
  parameter int CNT_W  = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  a25_flush_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [LINE_W-1:0] LAST = LINE_W'(LINES - 1);

  logic [1:0]        state_q, state_d;
  logic [LINE_W-1:0] addr_q, addr_d;
  logic              pend_q, pend_d;
  logic              en_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              trig;

  assign trig = bus.i_cache_flush |
                (en_q & ~bus.i_cache_enable);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (state_q == FLUSH): begin
        if (trig) pend_d = 1'b1;
        if (!bus.i_tag_busy) begin
          if (addr_q == LAST) state_d = DONE;
          else addr_d = addr_q + LINE_W'(1);
        end
      end
      (state_q == DONE): begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        addr_d = '0;
        pend_d = 1'b0;
        // back-to-back pass: no IDLE gap
        state_d = (pend_q | trig) ? FLUSH : IDLE;
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
        if (trig) state_d = FLUSH;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pend_q  <= 1'b0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      en_q    <= bus.i_cache_enable;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_tag_wen = (state_q == FLUSH) ?
                         {WAYS{~bus.i_tag_busy}} : '0;
  assign bus.o_tag_addr    = addr_q;
  assign bus.o_flush_busy  = (state_q != IDLE);
  assign bus.o_flush_done  = (state_q == DONE);
  assign bus.o_flush_count = cnt_q;
endmodule

// File: tb/tb_a25_flush_sequencer.sv
// tb_a25_flush_sequencer: scoreboard bench, LINES=4, CNT_W=2
// expected outputs queued per driven cycle, checked at negedge
module tb_a25_flush_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  a25_flush_sequencer_if #(
    .LINE_W(2), .WAYS(4), .CNT_W(2)
  ) bus ();

  a25_flush_sequencer #(
    .LINES(4), .LINE_W(2), .WAYS(4), .CNT_W(2)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0] wen;
    int         addr;
    logic       busy;
    logic       done;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  logic rst_lvl = 1'b1;
  logic en_lvl  = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @%0t got %0h exp %0h",
               tag, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("wen",  32'(bus.o_tag_wen),     32'(e.wen));
      chk("addr", 32'(bus.o_tag_addr),    32'(e.addr));
      chk("busy", 32'(bus.o_flush_busy),  32'(e.busy));
      chk("done", 32'(bus.o_flush_done),  32'(e.done));
      chk("cnt",  32'(bus.o_flush_count), 32'(e.cnt));
    end
  end

  task automatic cyc(input logic f, input logic tb,
                     input logic [3:0] ew, input int ea,
                     input logic eb, input logic ed,
                     input int ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst                = rst_lvl;
    bus.i_cache_flush  = f;
    bus.i_cache_enable = en_lvl;
    bus.i_tag_busy     = tb;
    e.wen  = ew;
    e.addr = ea;
    e.busy = eb;
    e.done = ed;
    e.cnt  = ec;
    sb.push_back(e);
  endtask

  task automatic idle(input logic f, input int ec);
    cyc(f, 1'b0, 4'h0, 0, 1'b0, 1'b0, ec);
  endtask

  task automatic wr(input int a, input int ec,
                    input logic f = 1'b0);
    cyc(f, 1'b0, 4'hF, a, 1'b1, 1'b0, ec);
  endtask

  task automatic hold(input int a, input int ec);
    cyc(1'b0, 1'b1, 4'h0, a, 1'b1, 1'b0, ec);
  endtask

  task automatic dn(input int ec, input logic f = 1'b0);
    cyc(f, 1'b0, 4'h0, 3, 1'b1, 1'b1, ec);
  endtask

  task automatic full(input int ec);
    for (int a = 0; a < 4; a++) wr(a, ec);
    dn(ec);
  endtask

  initial begin
    int c;
    bus.i_cache_flush  = 1'b0;
    bus.i_cache_enable = 1'b0;
    bus.i_tag_busy     = 1'b0;

    // reset state, then a plain pass
    idle(1'b0, 0);
    idle(1'b1, 0);
    rst_lvl = 1'b0;
    idle(1'b0, 0);
    idle(1'b1, 0);
    full(0);
    idle(1'b0, 1);

    // backpressure holds addr 1 for two cycles
    idle(1'b1, 1);
    wr(0, 1);
    hold(1, 1);
    hold(1, 1);
    wr(1, 1);
    wr(2, 1);
    wr(3, 1);
    dn(1);
    idle(1'b0, 2);

    // coalescing: three pulses, one extra pass
    rst_lvl = 1'b1;
    idle(1'b0, 0);
    rst_lvl = 1'b0;
    idle(1'b1, 0);
    wr(0, 0, 1'b1);
    wr(1, 0, 1'b1);
    wr(2, 0, 1'b1);
    wr(3, 0);
    dn(0);
    full(1);
    idle(1'b0, 2);
    idle(1'b0, 2);
    idle(1'b0, 2);

    // enable rise: nothing; fall: pass
    en_lvl = 1'b1;
    idle(1'b0, 2);
    idle(1'b0, 2);
    idle(1'b0, 2);
    en_lvl = 1'b0;
    idle(1'b0, 2);
    full(2);
    idle(1'b0, 3);

    // fall coincident with flush pulse: single pass
    en_lvl = 1'b1;
    idle(1'b0, 3);
    idle(1'b0, 3);
    en_lvl = 1'b0;
    idle(1'b1, 3);
    full(3);
    idle(1'b0, 3);
    idle(1'b0, 3);

    // reset while addr=2 aborts the pass
    idle(1'b1, 3);
    wr(0, 3);
    wr(1, 3);
    rst_lvl = 1'b1;
    idle(1'b0, 0);
    rst_lvl = 1'b0;
    for (int i = 0; i < 6; i++) idle(1'b0, 0);

    // saturating count: 1,2,3,3,3
    c = 0;
    for (int p = 0; p < 5; p++) begin
      idle(1'b1, c);
      full(c);
      if (c < 3) c++;
      idle(1'b0, c);
    end

    @(negedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
